// File: rtl/store_narrow_unit_pkg.sv
// Shared encodings for the store narrowing path.
// Size codes, completion codes and FSM states.
package store_narrow_unit_pkg;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;
  localparam logic [1:0] SZ_RSVD = 2'b11;

  localparam logic [1:0] ERR_OK    = 2'b00;
  localparam logic [1:0] ERR_ALIGN = 2'b01;
  localparam logic [1:0] ERR_TMO   = 2'b10;
  localparam logic [1:0] ERR_TRUNC = 2'b11;

  typedef logic [2:0] state_t;

  localparam state_t S_IDLE  = 3'd0;
  localparam state_t S_WRITE = 3'd1;
  localparam state_t S_DONE  = 3'd2;
  localparam state_t S_ERR   = 3'd3;
  localparam state_t S_ABORT = 3'd4;

  // High when narrowing would lose information (value is not a
  // sign-extension of the kept low bits).
  function automatic logic trunc_lossy(
    input logic [1:0]  size,
    input logic [31:0] data
  );
    logic bad;
    bad = 1'b0;
    if (size == SZ_BYTE)
      bad = (data[31:8] != {24{data[7]}});
    else if (size == SZ_HALF)
      bad = (data[31:16] != {16{data[15]}});
    return bad;
  endfunction

endpackage

// File: rtl/store_lane_align.sv
// Combinational byte-lane placement for narrowed stores.
// Produces byte enables, replicated lane data and a misalignment flag.
module store_lane_align
  import store_narrow_unit_pkg::*;
(
  input  logic [1:0]  size_i,
  input  logic [1:0]  off_i,
  input  logic [31:0] data_i,
  output logic [3:0]  be_o,
  output logic [31:0] data_o,
  output logic        mis_o
);

  always_comb begin
    be_o   = 4'b0000;
    data_o = data_i;
    mis_o  = 1'b0;
    unique case (1'b1)
      (size_i == SZ_BYTE): begin
        be_o   = 4'b0001 << off_i;
        data_o = {4{data_i[7:0]}};
      end
      (size_i == SZ_HALF): begin
        be_o   = off_i[1] ? 4'b1100 : 4'b0011;
        data_o = {2{data_i[15:0]}};
        mis_o  = off_i[0];
      end
      (size_i == SZ_WORD): begin
        be_o  = 4'b1111;
        mis_o = |off_i;
      end
      default: begin
        mis_o = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/store_narrow_unit.sv
// Store narrowing unit: sizes, aligns and writes register data to memory.
// Optional lossy-narrowing check: define STORE_NARROW_TRUNC_CHECK_EN.
module store_narrow_unit
  import store_narrow_unit_pkg::*;
#(
  parameter int ADDR_W  = 32,
  parameter int TIMEOUT = 15,
  parameter int CNT_W   = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              st_valid,
  output logic              st_ready,
  input  logic [1:0]        st_size,
  input  logic [ADDR_W-1:0] st_addr,
  input  logic [31:0]       st_wdata,
  output logic              st_done,
  output logic [1:0]        st_err,
  output logic              mem_req,
  input  logic              mem_ack,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [3:0]        mem_be,
  output logic [31:0]       mem_wdata
);

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [CNT_W-1:0]  cnt_inc;
  logic [1:0]        err_q, err_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [3:0]        be_q, be_d;
  logic [31:0]       wdata_q, wdata_d;

  logic [3:0]        lane_be;
  logic [31:0]       lane_data;
  logic              lane_mis;
  logic              trunc_bad;

  store_lane_align u_align (
    .size_i (st_size),
    .off_i  (st_addr[1:0]),
    .data_i (st_wdata),
    .be_o   (lane_be),
    .data_o (lane_data),
    .mis_o  (lane_mis)
  );

`ifdef STORE_NARROW_TRUNC_CHECK_EN
  assign trunc_bad = trunc_lossy(st_size, st_wdata);
`else
  assign trunc_bad = 1'b0;
`endif

  assign cnt_inc = cnt_q + 1'b1;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    err_d   = ERR_OK;
    addr_d  = addr_q;
    be_d    = be_q;
    wdata_d = wdata_q;
    unique case (state_q)
      S_IDLE: begin
        cnt_d = '0;
        if (st_valid) begin
          if (lane_mis) begin
            state_d = S_ERR;
            err_d   = ERR_ALIGN;
          end else if (trunc_bad) begin
            state_d = S_ERR;
            err_d   = ERR_TRUNC;
          end else begin
            state_d = S_WRITE;
            addr_d  = {st_addr[ADDR_W-1:2], 2'b00};
            be_d    = lane_be;
            wdata_d = lane_data;
          end
        end
      end
      S_WRITE: begin
        // An ack arriving on the final allowed cycle still completes.
        if (mem_ack) begin
          state_d = S_DONE;
          cnt_d   = '0;
        end else if (cnt_inc == CNT_W'(TIMEOUT)) begin
          state_d = S_ABORT;
          err_d   = ERR_TMO;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      S_DONE, S_ERR, S_ABORT: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      err_q   <= ERR_OK;
      addr_q  <= '0;
      be_q    <= 4'b0000;
      wdata_q <= 32'h0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
      addr_q  <= addr_d;
      be_q    <= be_d;
      wdata_q <= wdata_d;
    end
  end

  assign st_ready  = (state_q == S_IDLE);
  assign mem_req   = (state_q == S_WRITE);
  assign st_done   = (state_q == S_DONE) || (state_q == S_ERR)
                  || (state_q == S_ABORT);
  assign st_err    = err_q;
  assign mem_addr  = addr_q;
  assign mem_be    = be_q;
  assign mem_wdata = wdata_q;

endmodule
